ysyx_040750_mul_ctrl: RTL and testbench
=======================================

# ysyx_040750_mul_ctrl

Sequencing controller for the radix-4 serial Booth multiplier (`ysyx_040750_booth_mul_serial`) in the EXU of the full-pipeline core. It accepts RV64M multiply ops with a valid/ready handshake and derives operand sign-extension flags. It launches the multiplier, captures the 128-bit product, and returns a 64-bit result selected and formatted per op. A one-entry product cache serves back-to-back MULH*/MUL pairs on identical operands without re-running the multiplier. A flush aborts the op in flight, and any product still in flight from the aborted op is discarded.

## Interface
Parameters:
- none; op encodings come from the shared package.

Ports:
- `clk`  in  1  clock, rising edge.
- `rst_n`  in  1  reset, asynchronous, active-low.
- `in_valid`  in  1  op request.
- `in_ready`  out  1  controller can accept an op.
- `in_op`  in  3  MUL=0, MULH=1, MULHSU=2, MULHU=3, MULW=4; codes 5–7 are treated as MUL.
- `in_rs1`, `in_rs2`  in  64 each  operands.
- `out_valid`  out  1  result valid.
- `out_ready`  in  1  consumer takes the result.
- `out_result`  out  64  formatted result.
- `flush`  in  1  pipeline flush; has priority over everything else.
- `m_mul1`, `m_mul2`  out  64 each  multiplier operands.
- `m_sext_flag`  out  2  {rs1 signed, rs2 signed}.
- `m_mul_valid`  out  1  one-cycle launch pulse.
- `m_P_valid`  in  1  product ready.
- `m_P`  in  128  product.

## Operation
- Decided: one clock; reset is asynchronous and active-low.
- States: IDLE, ISSUE, BUSY, DONE, DRAIN.
- `in_ready` = (state==IDLE) & ~flush.
- An op is accepted when `in_valid & in_ready`.
- On accept, the controller latches op, rs1, rs2 and computes sext:
  - MUL, MULW, MULH → 11.
  - MULHSU → 10.
  - MULHU → 00.
- Cache hit rules:
  - Entry holds valid, rs1, rs2, sext and the 128-bit product.
  - MUL hits on rs1/rs2 match, regardless of sext.
  - All other ops hit on rs1/rs2/sext match.
  - MULW hits only on a full 64-bit operand match.
- Hit: IDLE→DONE, with the product taken from the cache.
- Miss: IDLE→ISSUE.
- ISSUE:
  - Drives `m_mul_valid`=1 for exactly one cycle, with `m_mul1`/`m_mul2`/`m_sext_flag` from the latched values.
  - Clears cache valid.
  - Goes to BUSY.
- `m_mul1`/`m_mul2`/`m_sext_flag` hold their latched values in all states.
- BUSY: waits for `m_P_valid`. On that cycle it captures `m_P` into the product register and the cache (valid=1, tags = latched operands/sext), then goes to DONE.
- DONE: `out_valid`=1, held until `out_ready`, then goes to IDLE.
- Result format, computed from the product register:
  - MUL: P[63:0].
  - MULH/MULHSU/MULHU: P[127:64].
  - MULW: {{32{P[31]}},P[31:0]}.
- Flush handling:
  - IDLE: no effect; a request in the same cycle is not accepted.
  - ISSUE: the pulse is still issued, then → DRAIN.
  - BUSY with `m_P_valid` low: → DRAIN.
  - BUSY with `m_P_valid` high: → IDLE, product dropped, cache not written.
  - DONE: → IDLE, `out_valid` drops next cycle.
- DRAIN: ignores inputs (`in_ready`=0) and waits for `m_P_valid`, then → IDLE without capturing.
- Reset mid-operation: all state returns to reset values immediately (asynchronous). The multiplier is reset by the same top-level reset, so no drain is needed.

## Timing
- Reset values:
  - `in_ready`=1 (IDLE).
  - `out_valid`=0.
  - `out_result`=0.
  - `m_mul_valid`=0.
  - `m_mul1`=`m_mul2`=0.
  - `m_sext_flag`=00.
  - Cache valid=0.
- Accept at cycle 0 is followed by:
  - Miss: ISSUE in cycle 1 (`m_mul_valid`=1); multiplier `m_P_valid` no earlier than cycle 2 and no later than cycle 34; `out_valid` the cycle after capture, i.e. worst case cycle 35, best case cycle 3.
  - Hit: `out_valid` in cycle 1.
- `out_result` is stable while `out_valid`=1.
- Next accept is possible no earlier than the cycle after the `out_valid & out_ready` cycle.
- `m_mul_valid` is never asserted outside ISSUE.
- `m_P_valid` is ignored in IDLE, ISSUE and DONE.

## Structure
- Package `ysyx_040750_mul_pkg` holds:
  - Op codes `MUL_OP_*` (3-bit).
  - State enum localparams (3-bit).
  - Sext encodings.
- Sub-module `ysyx_040750_mul_cache`: the one-entry tag/product register and hit compare.
- FSM, format mux and multiplier port drivers stay in the top.
- The multiplier is instantiated by the EXU, not inside this block.

## Test plan
- Miss path: MULHU rs1=2^64-1, rs2=2 → `m_sext_flag`=00, one `m_mul_valid` pulse; `out_result`=0x1; latency within 3–35 cycles.
- Cache hit: MULH rs1=-3, rs2=5 → 0xFFFFFFFFFFFFFFFF; then MUL with the same operands → 0xFFFFFFFFFFFFFFF1 with `out_valid` in cycle 1 and no `m_mul_valid`.
- Sext-mismatch miss: MULHSU rs1=-1, rs2=2 after a MULH with identical operands → multiplier re-run with sext=10; result 0xFFFFFFFFFFFFFFFF.
- MULW formatting: rs1=0x7FFFFFFF, rs2=2 → 0xFFFFFFFFFFFFFFFE.
- Flush while BUSY: flush 3 cycles after ISSUE → DRAIN, `in_ready`=0 until stale `m_P_valid`; no `out_valid`; next MUL 6×7 returns 42 and the cache shows a miss.
- Backpressure and reset: `out_ready`=0 for 10 cycles holds `out_valid`/result stable; asserting `rst_n`=0 mid-BUSY clears all outputs the same cycle.

Source files
------------

// File: rtl/ysyx_040750_mul_pkg.sv
// Shared definitions for the RV64M multiply sequencing controller:
// op codes, FSM states, sign-extension encodings and the cache tag layout.
package ysyx_040750_mul_pkg;

    localparam int MUL_OP_W = 3;

    localparam logic [MUL_OP_W-1:0] MUL_OP_MUL    = 3'd0;
    localparam logic [MUL_OP_W-1:0] MUL_OP_MULH   = 3'd1;
    localparam logic [MUL_OP_W-1:0] MUL_OP_MULHSU = 3'd2;
    localparam logic [MUL_OP_W-1:0] MUL_OP_MULHU  = 3'd3;
    localparam logic [MUL_OP_W-1:0] MUL_OP_MULW   = 3'd4;

    // {rs1 signed, rs2 signed}
    localparam logic [1:0] SEXT_SS = 2'b11;
    localparam logic [1:0] SEXT_SU = 2'b10;
    localparam logic [1:0] SEXT_UU = 2'b00;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_ISSUE = 3'd1,
        ST_BUSY  = 3'd2,
        ST_DONE  = 3'd3,
        ST_DRAIN = 3'd4
    } mul_state_e;

    typedef struct packed {
        logic [63:0] rs1;
        logic [63:0] rs2;
        logic [1:0]  sext;
    } mul_tag_t;

    // Reserved encodings 5..7 behave as a plain MUL.
    function automatic logic [MUL_OP_W-1:0] norm_op(input logic [MUL_OP_W-1:0] op);
        return (op > MUL_OP_MULW) ? MUL_OP_MUL : op;
    endfunction

    function automatic logic [1:0] op_sext(input logic [MUL_OP_W-1:0] op);
        logic [1:0] sx;
        case (op)
            MUL_OP_MULHSU: sx = SEXT_SU;
            MUL_OP_MULHU:  sx = SEXT_UU;
            default:       sx = SEXT_SS;
        endcase
        return sx;
    endfunction

endpackage

// File: rtl/ysyx_040750_mul_ctrl_if.sv
// Request/response handshake plus the serial Booth multiplier port bundle.
interface ysyx_040750_mul_ctrl_if;
    import ysyx_040750_mul_pkg::*;

    logic                in_valid;
    logic                in_ready;
    logic [MUL_OP_W-1:0] in_op;
    logic [63:0]         in_rs1;
    logic [63:0]         in_rs2;

    logic                out_valid;
    logic                out_ready;
    logic [63:0]         out_result;

    logic [63:0]         m_mul1;
    logic [63:0]         m_mul2;
    logic [1:0]          m_sext_flag;
    logic                m_mul_valid;
    logic                m_P_valid;
    logic [127:0]        m_P;

    modport slave (
        input  in_valid, in_op, in_rs1, in_rs2, out_ready, m_P_valid, m_P,
        output in_ready, out_valid, out_result,
        output m_mul1, m_mul2, m_sext_flag, m_mul_valid
    );

    modport master (
        output in_valid, in_op, in_rs1, in_rs2, out_ready, m_P_valid, m_P,
        input  in_ready, out_valid, out_result,
        input  m_mul1, m_mul2, m_sext_flag, m_mul_valid
    );

endinterface

// File: rtl/ysyx_040750_mul_cache.sv
// One-entry product cache: operand/sext tag, 128-bit product and hit compare.
module ysyx_040750_mul_cache
    import ysyx_040750_mul_pkg::*;
(
    input  logic                clk,
    input  logic                rst_n,
    input  logic                i_clr,
    input  logic                i_wr,
    input  mul_tag_t            i_wr_tag,
    input  logic [127:0]        i_wr_prod,
    input  logic [MUL_OP_W-1:0] i_lk_op,
    input  mul_tag_t            i_lk_tag,
    output logic                o_hit,
    output logic [127:0]        o_prod
);

    logic         r_vld;
    mul_tag_t     r_tag;
    logic [127:0] r_prod;

    logic w_opnd_match;
    logic w_sext_match;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_vld <= 1'b0;
        end else if (i_wr) begin
            r_vld <= 1'b1;
        end else if (i_clr) begin
            r_vld <= 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (i_wr) begin
            r_tag  <= i_wr_tag;
            r_prod <= i_wr_prod;
        end
    end

    // The low 64 product bits do not depend on operand signedness, so a
    // plain MUL may reuse any cached product with matching operands.
    assign w_opnd_match = (r_tag.rs1 == i_lk_tag.rs1) && (r_tag.rs2 == i_lk_tag.rs2);
    assign w_sext_match = (r_tag.sext == i_lk_tag.sext);
    assign o_hit        = r_vld && w_opnd_match && ((i_lk_op == MUL_OP_MUL) || w_sext_match);
    assign o_prod       = r_prod;

endmodule

// File: rtl/ysyx_040750_mul_ctrl.sv
// RV64M multiply sequencer: accepts ops, launches the serial Booth multiplier
// (or reuses the cached product), and returns the formatted 64-bit result.
module ysyx_040750_mul_ctrl
    import ysyx_040750_mul_pkg::*;
(
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  flush,
    ysyx_040750_mul_ctrl_if.slave bus
);

    mul_state_e          r_state;
    logic [MUL_OP_W-1:0] r_op;
    logic [63:0]         r_rs1;
    logic [63:0]         r_rs2;
    logic [1:0]          r_sext;
    logic [127:0]        r_prod;
    logic                r_mul_valid;
    logic                r_out_valid;

    logic [MUL_OP_W-1:0] w_op_norm;
    logic [1:0]          w_sext_in;
    logic                w_accept;
    logic                w_hit;
    logic [127:0]        w_cache_prod;
    logic                w_cache_clr;
    logic                w_cache_wr;
    mul_tag_t            w_lk_tag;
    mul_tag_t            w_wr_tag;

    function automatic logic [63:0] fmt_result(input logic [MUL_OP_W-1:0] op,
                                               input logic [127:0]        p);
        logic [63:0] res;
        case (op)
            MUL_OP_MULH,
            MUL_OP_MULHSU,
            MUL_OP_MULHU: res = p[127:64];
            MUL_OP_MULW:  res = {{32{p[31]}}, p[31:0]};
            default:      res = p[63:0];
        endcase
        return res;
    endfunction

    assign w_op_norm = norm_op(bus.in_op);
    assign w_sext_in = op_sext(w_op_norm);
    assign w_accept  = bus.in_valid && bus.in_ready;

    assign w_lk_tag  = '{rs1: bus.in_rs1, rs2: bus.in_rs2, sext: w_sext_in};
    assign w_wr_tag  = '{rs1: r_rs1, rs2: r_rs2, sext: r_sext};

    // A product landing together with a flush belongs to an aborted op.
    assign w_cache_clr = (r_state == ST_ISSUE);
    assign w_cache_wr  = (r_state == ST_BUSY) && bus.m_P_valid && !flush;

    ysyx_040750_mul_cache u_cache (
        .clk       (clk),
        .rst_n     (rst_n),
        .i_clr     (w_cache_clr),
        .i_wr      (w_cache_wr),
        .i_wr_tag  (w_wr_tag),
        .i_wr_prod (bus.m_P),
        .i_lk_op   (w_op_norm),
        .i_lk_tag  (w_lk_tag),
        .o_hit     (w_hit),
        .o_prod    (w_cache_prod)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= ST_IDLE;
            r_op        <= MUL_OP_MUL;
            r_rs1       <= '0;
            r_rs2       <= '0;
            r_sext      <= SEXT_UU;
            r_prod      <= '0;
            r_mul_valid <= 1'b0;
            r_out_valid <= 1'b0;
        end else begin
            r_mul_valid <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (w_accept) begin
                        r_op   <= w_op_norm;
                        r_rs1  <= bus.in_rs1;
                        r_rs2  <= bus.in_rs2;
                        r_sext <= w_sext_in;
                        if (w_hit) begin
                            r_prod      <= w_cache_prod;
                            r_out_valid <= 1'b1;
                            r_state     <= ST_DONE;
                        end else begin
                            r_mul_valid <= 1'b1;
                            r_state     <= ST_ISSUE;
                        end
                    end
                end
                // The launch pulse is already on the wire; a flush here only
                // means its product must be swallowed later.
                ST_ISSUE: begin
                    r_state <= flush ? ST_DRAIN : ST_BUSY;
                end
                ST_BUSY: begin
                    if (bus.m_P_valid) begin
                        if (flush) begin
                            r_state <= ST_IDLE;
                        end else begin
                            r_prod      <= bus.m_P;
                            r_out_valid <= 1'b1;
                            r_state     <= ST_DONE;
                        end
                    end else if (flush) begin
                        r_state <= ST_DRAIN;
                    end
                end
                ST_DONE: begin
                    if (flush || bus.out_ready) begin
                        r_out_valid <= 1'b0;
                        r_state     <= ST_IDLE;
                    end
                end
                ST_DRAIN: begin
                    if (bus.m_P_valid) begin
                        r_state <= ST_IDLE;
                    end
                end
                default: begin
                    r_out_valid <= 1'b0;
                    r_state     <= ST_IDLE;
                end
            endcase
        end
    end

    assign bus.in_ready    = (r_state == ST_IDLE) && !flush;
    assign bus.out_valid   = r_out_valid;
    assign bus.out_result  = fmt_result(r_op, r_prod);
    assign bus.m_mul1      = r_rs1;
    assign bus.m_mul2      = r_rs2;
    assign bus.m_sext_flag = r_sext;
    assign bus.m_mul_valid = r_mul_valid;

endmodule

// File: tb/tb_ysyx_040750_mul_ctrl.sv
// Bench for the multiply sequencer: transaction-level reference model with a
// per-cycle compare, a behavioural variable-latency multiplier, and directed cases.
module tb_ysyx_040750_mul_ctrl;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    logic flush = 1'b0;

    ysyx_040750_mul_ctrl_if bus ();

    ysyx_040750_mul_ctrl dut (
        .clk   (clk),
        .rst_n (rst_n),
        .flush (flush),
        .bus   (bus)
    );

    initial forever #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s actual=%h required=%h at %0t", nm, act, req, $time);
        end
    endtask

    // ---------------- reference arithmetic ----------------
    function automatic logic [2:0] ref_norm(input logic [2:0] op);
        return (op > 3'd4) ? 3'd0 : op;
    endfunction

    function automatic logic [1:0] ref_sext(input logic [2:0] op);
        logic [2:0] n;
        n = ref_norm(op);
        if (n == 3'd2) return 2'b10;
        if (n == 3'd3) return 2'b00;
        return 2'b11;
    endfunction

    function automatic logic [127:0] ref_prod(input logic [63:0] a, input logic [63:0] b,
                                              input logic [1:0] sx);
        logic signed [129:0] ea, eb, pr;
        ea = sx[1] ? $signed({{66{a[63]}}, a}) : $signed({66'd0, a});
        eb = sx[0] ? $signed({{66{b[63]}}, b}) : $signed({66'd0, b});
        pr = ea * eb;
        return pr[127:0];
    endfunction

    function automatic logic [63:0] ref_result(input logic [2:0] op, input logic [63:0] a,
                                               input logic [63:0] b);
        logic [2:0]   n;
        logic [127:0] p;
        n = ref_norm(op);
        p = ref_prod(a, b, ref_sext(op));
        case (n)
            3'd1, 3'd2, 3'd3: return p[127:64];
            3'd4:             return {{32{p[31]}}, p[31:0]};
            default:          return p[63:0];
        endcase
    endfunction

    // ---------------- behavioural multiplier ----------------
    int           lat_force = 0;
    bit           mp_pend   = 1'b0;
    int           mp_cnt    = 0;
    logic [127:0] mp_pp     = '0;

    initial begin
        bus.m_P_valid = 1'b0;
        bus.m_P       = '0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                mp_pend = 1'b0;
            end else if (bus.m_mul_valid) begin
                mp_pend = 1'b1;
                mp_cnt  = (lat_force > 0) ? lat_force : int'($urandom_range(1, 33));
                mp_pp   = ref_prod(bus.m_mul1, bus.m_mul2, bus.m_sext_flag);
            end
            @(posedge clk);
            #1;
            bus.m_P_valid = 1'b0;
            if (mp_pend && rst_n) begin
                mp_cnt--;
                if (mp_cnt == 0) begin
                    bus.m_P_valid = 1'b1;
                    bus.m_P       = mp_pp;
                    mp_pend       = 1'b0;
                end
            end
        end
    end

    // ---------------- transaction model + per-cycle compare ----------------
    bit          md_idle = 1'b1, md_pulse = 1'b0, md_out = 1'b0, md_wait = 1'b0, md_drain = 1'b0;
    logic [63:0] md_res = '0, md_m1 = '0, md_m2 = '0;
    logic [1:0]  md_sx = 2'b00;
    logic [2:0]  cur_op = 3'd0;
    logic [63:0] cur_a = '0, cur_b = '0;
    bit          c_vld = 1'b0;
    logic [63:0] c_a = '0, c_b = '0;
    logic [1:0]  c_sx = 2'b00;

    always @(negedge clk) begin
        if (!rst_n) begin
            chk("rst_in_ready", bus.in_ready, 1'b1);
            chk("rst_out_valid", bus.out_valid, 1'b0);
            chk("rst_out_result", bus.out_result, 64'd0);
            chk("rst_mul_valid", bus.m_mul_valid, 1'b0);
            chk("rst_mul1", bus.m_mul1, 64'd0);
            chk("rst_mul2", bus.m_mul2, 64'd0);
            chk("rst_sext", bus.m_sext_flag, 2'b00);
            md_idle = 1'b1; md_pulse = 1'b0; md_out = 1'b0; md_wait = 1'b0; md_drain = 1'b0;
            md_res = '0; md_m1 = '0; md_m2 = '0; md_sx = 2'b00; c_vld = 1'b0;
        end else begin
            chk("in_ready", bus.in_ready, md_idle && !flush);
            chk("mul_valid", bus.m_mul_valid, md_pulse);
            chk("mul1", bus.m_mul1, md_m1);
            chk("mul2", bus.m_mul2, md_m2);
            chk("sext", bus.m_sext_flag, md_sx);
            chk("out_valid", bus.out_valid, md_out);
            if (md_out) chk("out_result", bus.out_result, md_res);

            if (md_out) begin
                if (flush || bus.out_ready) begin
                    md_out  = 1'b0;
                    md_idle = 1'b1;
                end
            end else if (md_pulse) begin
                md_pulse = 1'b0;
                if (flush) md_drain = 1'b1;
                else       md_wait  = 1'b1;
            end else if (md_wait) begin
                if (bus.m_P_valid) begin
                    md_wait = 1'b0;
                    if (flush) begin
                        md_idle = 1'b1;
                    end else begin
                        c_vld = 1'b1; c_a = cur_a; c_b = cur_b; c_sx = ref_sext(cur_op);
                        md_out = 1'b1;
                        md_res = ref_result(cur_op, cur_a, cur_b);
                    end
                end else if (flush) begin
                    md_wait  = 1'b0;
                    md_drain = 1'b1;
                end
            end else if (md_drain) begin
                if (bus.m_P_valid) begin
                    md_drain = 1'b0;
                    md_idle  = 1'b1;
                end
            end else if (md_idle && bus.in_valid && !flush) begin
                md_idle = 1'b0;
                cur_op = ref_norm(bus.in_op); cur_a = bus.in_rs1; cur_b = bus.in_rs2;
                md_m1 = cur_a; md_m2 = cur_b; md_sx = ref_sext(cur_op);
                if (c_vld && c_a == cur_a && c_b == cur_b && (cur_op == 3'd0 || c_sx == md_sx)) begin
                    md_out = 1'b1;
                    md_res = ref_result(cur_op, cur_a, cur_b);
                end else begin
                    md_pulse = 1'b1;
                    c_vld    = 1'b0;
                end
            end
        end
    end

    // ---------------- driver helpers ----------------
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic accept_op(input logic [2:0] op, input logic [63:0] a, input logic [63:0] b);
        int n;
        n = 0;
        while (!bus.in_ready && n < 100) begin
            step();
            n++;
        end
        chk("accept_ready", bus.in_ready, 1'b1);
        bus.in_valid = 1'b1;
        bus.in_op    = op;
        bus.in_rs1   = a;
        bus.in_rs2   = b;
        step();
        bus.in_valid = 1'b0;
    endtask

    task automatic op_lit(input string nm, input logic [2:0] op, input logic [63:0] a,
                          input logic [63:0] b, input logic [63:0] lit, input int lmin,
                          input int lmax);
        int lat;
        accept_op(op, a, b);
        lat = 1;
        while (!bus.out_valid && lat < 60) begin
            step();
            lat++;
        end
        chk({nm, "_valid"}, bus.out_valid, 1'b1);
        chk({nm, "_res"}, bus.out_result, lit);
        total++;
        if (lat < lmin || lat > lmax) begin
            bad++;
            $display("FAIL %s_latency actual=%0d required=%0d..%0d", nm, lat, lmin, lmax);
        end
        step();
    endtask

    logic [63:0] pool [8];

    initial begin
        int n;
        bus.in_valid  = 1'b0;
        bus.in_op     = 3'd0;
        bus.in_rs1    = '0;
        bus.in_rs2    = '0;
        bus.out_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;
        step();

        op_lit("mulhu", 3'd3, 64'hFFFF_FFFF_FFFF_FFFF, 64'd2, 64'h1, 3, 35);
        op_lit("mulh", 3'd1, -64'sd3, 64'd5, 64'hFFFF_FFFF_FFFF_FFFF, 3, 35);
        op_lit("mul_hit", 3'd0, -64'sd3, 64'd5, 64'hFFFF_FFFF_FFFF_FFF1, 1, 1);
        op_lit("mulh_pre", 3'd1, -64'sd1, 64'd2, 64'hFFFF_FFFF_FFFF_FFFF, 1, 35);
        op_lit("mulhsu", 3'd2, -64'sd1, 64'd2, 64'hFFFF_FFFF_FFFF_FFFF, 3, 35);
        op_lit("mulw", 3'd4, 64'h7FFF_FFFF, 64'd2, 64'hFFFF_FFFF_FFFF_FFFE, 3, 35);
        op_lit("op7_as_mul", 3'd7, 64'd9, 64'd11, 64'd99, 3, 35);

        // Flush three cycles after the launch pulse, then wait out the stale product.
        lat_force = 10;
        accept_op(3'd1, 64'd5, 64'd9);
        chk("flush_issue_pulse", bus.m_mul_valid, 1'b1);
        repeat (3) step();
        flush = 1'b1;
        step();
        flush = 1'b0;
        chk("drain_ready", bus.in_ready, 1'b0);
        chk("drain_no_out", bus.out_valid, 1'b0);
        n = 0;
        while (!bus.in_ready && n < 50) begin
            step();
            n++;
        end
        chk("drain_exit", bus.in_ready, 1'b1);
        lat_force = 0;
        op_lit("mul42", 3'd0, 64'd6, 64'd7, 64'd42, 3, 35);

        // Backpressure holds the result steady.
        bus.out_ready = 1'b0;
        accept_op(3'd0, 64'h10, 64'h10);
        n = 0;
        while (!bus.out_valid && n < 60) begin
            step();
            n++;
        end
        for (int i = 0; i < 10; i++) begin
            chk("bp_valid", bus.out_valid, 1'b1);
            chk("bp_result", bus.out_result, 64'h100);
            step();
        end
        bus.out_ready = 1'b1;
        step();
        chk("bp_released", bus.out_valid, 1'b0);

        // Asynchronous reset in the middle of a multiply.
        lat_force = 20;
        accept_op(3'd1, 64'd3, 64'd4);
        repeat (5) step();
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_out_valid", bus.out_valid, 1'b0);
        chk("arst_mul_valid", bus.m_mul_valid, 1'b0);
        chk("arst_mul1", bus.m_mul1, 64'd0);
        chk("arst_mul2", bus.m_mul2, 64'd0);
        chk("arst_sext", bus.m_sext_flag, 2'b00);
        chk("arst_result", bus.out_result, 64'd0);
        chk("arst_ready", bus.in_ready, 1'b1);
        step();
        rst_n = 1'b1;
        lat_force = 0;
        step();
        op_lit("post_rst", 3'd1, 64'd3, 64'd4, 64'd0, 3, 35);

        // Randomized traffic with a small operand pool so cache hits happen.
        pool[0] = 64'd2;
        pool[1] = 64'h1_0000_0002;
        pool[2] = 64'hFFFF_FFFF_FFFF_FFFF;
        pool[3] = 64'h7FFF_FFFF;
        pool[4] = 64'h8000_0000_0000_0000;
        pool[5] = 64'd0;
        pool[6] = {$urandom, $urandom};
        pool[7] = {$urandom, $urandom};
        for (int i = 0; i < 3000; i++) begin
            bus.out_ready = ($urandom_range(0, 9) < 7);
            flush         = ($urandom_range(0, 99) < 4);
            bus.in_valid  = ($urandom_range(0, 9) < 6);
            bus.in_op     = 3'($urandom_range(0, 7));
            bus.in_rs1    = pool[$urandom_range(0, 7)];
            bus.in_rs2    = pool[$urandom_range(0, 7)];
            step();
        end
        flush         = 1'b0;
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        repeat (60) step();
        chk("final_idle", bus.in_ready, 1'b1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #800000;
        $display("FAIL watchdog expired total=%0d bad=%0d", total, bad);
        $fatal(1);
    end

endmodule
